conv1d_engine: RTL and testbench
================================

Name: conv1d_engine

Overview:
- Parametrised 1-D convolution datapath and control for the conv1d accelerator. Next generation of the fixed-function core.
- Reads kernel coefficients and input samples from the accelerator's single-port internal SRAM, performs signed multiply-accumulate, and writes results back to the same SRAM.
- Adds over the previous core: configurable sample width, kernel length, stride, valid/same padding, arithmetic shift with optional saturation, abort, and error reporting.
- Sits between the control registers (config/status) and the SRAM request mux. Its ext_gnt_o drives the mux select that grants the external OBI bridge.

Parameters:
- NumWords, 128, SRAM depth in 32-bit words; AddrWidth = $clog2(NumWords).
- DataWidth, 16, signed sample/coefficient width (2..32). Stored in word LSBs.
- AccWidth, 40, signed accumulator width; must be >= 2*DataWidth.
- MaxKernelLen, 16, kernel register-file depth; KW = $clog2(MaxKernelLen+1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1.
- abort_i  in  1  cancel current operation.
- cfg_in_base_i  in  AddrWidth  input vector word address.
- cfg_kern_base_i  in  AddrWidth  kernel word address.
- cfg_out_base_i  in  AddrWidth  output word address.
- cfg_in_len_i  in  AddrWidth+1  input length N.
- cfg_kern_len_i  in  KW  kernel length K.
- cfg_stride_i  in  4  stride S; 0 is treated as 1.
- cfg_same_i  in  1  0 = valid mode, 1 = same (zero-pad) mode.
- cfg_shift_i  in  $clog2(AccWidth)  arithmetic right shift applied to the result.
- cfg_sat_i  in  1  1 = saturate result to DataWidth, 0 = truncate.
- busy_o  out  1  engine owns the SRAM.
- done_o  out  1  one-cycle pulse on completion.
- err_o  out  1  sticky config error; cleared by the next accepted start.
- out_count_o  out  AddrWidth+1  outputs written so far.
- ext_gnt_o  out  1  equals !busy_o; external bus may use the SRAM.
- mem_req_o, mem_we_o  out  1  SRAM request and write enable.
- mem_addr_o  out  AddrWidth  SRAM word address.
- mem_wdata_o  out  32  SRAM write data.
- mem_be_o  out  4  SRAM byte enables; always 4'hF on writes.
- mem_rdata_i  in  32  SRAM read data; valid the cycle after the read request.

Behaviour:
- Reset: every output is 0 except ext_gnt_o=1. FSM state is IDLE, and the accumulator and kernel register file are cleared.
- Config capture: all cfg_* inputs are registered on the accepted start. Later changes have no effect on the running operation.
- Output count, valid mode: Nout = (N-K)/S + 1, pad P = 0.
- Output count, same mode: Nout = ceil(N/S), P = (K-1)/2.
- Error check: K=0, K>MaxKernelLen, N=0, or (valid mode and K>N). On error: IDLE→DONE directly, err_o=1, done_o pulses, no SRAM access.
- IDLE: on start_i, go to LD_KERN.
- LD_KERN:
  - Issues reads at kern_base+i, i = 0..K-1, one per cycle.
  - Captures mem_rdata_i[DataWidth-1:0] into kreg[i-1] each cycle after a read.
  - One drain cycle follows the last read. Duration K+1 cycles. Then go to MAC with j=0.
- MAC (output j):
  - For i = 0..K-1, one per cycle, idx = j*S + i - P.
  - If 0 <= idx < N: read in_base+idx.
  - Otherwise no request, and the tap contributes 0 (padding).
  - acc starts at 0. Each returned sample is sign-extended and acc += x*kreg[i], one cycle after its issue.
  - One drain cycle follows the last tap, then WRITE.
- WRITE:
  - r = acc >>> shift.
  - If sat: clamp to [-2^(DataWidth-1), 2^(DataWidth-1)-1]; else take the low DataWidth bits.
  - Write sign-extended r to out_base+j, be=4'hF, and increment out_count_o.
  - If j = Nout-1, go to DONE; else j++ and go to MAC.
- DONE: done_o=1 for one cycle, then IDLE.
- Timing: busy_o is high from the cycle after start through the DONE cycle. A valid run takes exactly (K+1) + Nout*(K+2) + 1 busy cycles.
- Addressing: all addresses wrap modulo NumWords. The engine does not check overlap between input, kernel and output regions; in-place operation is undefined.
- Abort: abort_i in any busy state forces IDLE next cycle. No further SRAM requests, no done_o, out_count_o holds. Abort takes priority over a simultaneous state transition.
- Start and abort together in IDLE: abort wins and start is dropped.
- Reset asserted mid-operation: returns to reset values on the next clock edge.
- Arithmetic: products are full 2*DataWidth signed, and the accumulator wraps at AccWidth.

Test Plan:
- Valid mode, N=8, K=3, S=1, in=1..8, kern={1,2,3}, shift=0 → 6 outputs: 14,20,26,32,38,44. done_o pulses after exactly 4+6*5+1=35 busy cycles.
- Same mode, N=5, K=3, S=1, in=1..5, kern={1,1,1} → outputs 3,6,9,12,9. No SRAM read is issued for idx=-1 or idx=5.
- Stride: valid mode, N=9, K=2, S=3, in=0..8, kern={1,1} → 3 outputs: 1,7,13 at out_base..out_base+2.
- Saturation: DataWidth=16, in=30000 x4, kern={2,2}, shift=0. With sat=1 → 32767 written as 32'h00007FFF. With sat=0 → truncated 16'hD4C0 written as 32'hFFFFD4C0.
- Errors: K=0 → err_o=1 and done_o next cycle with zero SRAM requests. Valid mode with K=5, N=4 → same. The next good start clears err_o.
- Abort and grant: abort_i raised in MAC of output 2 → IDLE next cycle, out_count_o=2, no done_o, ext_gnt_o=1. A start_i pulse while busy is ignored.

Source files
------------

// File: rtl/conv1d_engine_if.sv
// conv1d_engine_if: single-port SRAM request bus between the conv1d engine and the SRAM mux
// Signals: req/we/addr/wdata/be from master; rdata from slave, valid the cycle after a read request.
interface conv1d_engine_if #(
    parameter int AddrWidth = 7
);
    logic                 req;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic [3:0]           be;
    logic [31:0]          rdata;

    modport master (output req, we, addr, wdata, be, input rdata);
    modport slave  (input req, we, addr, wdata, be, output rdata);
endinterface

// File: rtl/conv1d_engine.sv
// conv1d_engine: 1-D convolution engine; loads kernel and samples from SRAM, MACs, writes results back
// Ports: clk_i/rst_ni clock and sync active-low reset; start_i/abort_i control; cfg_* captured on start;
//        busy_o/done_o/err_o/out_count_o status; ext_gnt_o grants the SRAM to the external bridge;
//        mem SRAM master port.
module conv1d_engine #(
    parameter int  NumWords     = 128,
    parameter int  DataWidth    = 16,
    parameter int  AccWidth     = 40,
    parameter int  MaxKernelLen = 16,
    localparam int AddrWidth    = $clog2(NumWords),
    localparam int KW           = $clog2(MaxKernelLen + 1),
    localparam int SW           = $clog2(AccWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [AddrWidth-1:0] cfg_in_base_i,
    input  logic [AddrWidth-1:0] cfg_kern_base_i,
    input  logic [AddrWidth-1:0] cfg_out_base_i,
    input  logic [AddrWidth:0]   cfg_in_len_i,
    input  logic [KW-1:0]        cfg_kern_len_i,
    input  logic [3:0]           cfg_stride_i,
    input  logic                 cfg_same_i,
    input  logic [SW-1:0]        cfg_shift_i,
    input  logic                 cfg_sat_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [AddrWidth:0]   out_count_o,
    output logic                 ext_gnt_o,
    conv1d_engine_if.master      mem
);
    localparam int NW  = AddrWidth + 1;
    localparam int IW  = NW + 6;
    localparam int KIW = $clog2(MaxKernelLen);
    localparam logic signed [AccWidth-1:0] MAXV = AccWidth'({(DataWidth - 1){1'b1}});
    localparam logic signed [AccWidth-1:0] MINV = ~MAXV;

    typedef enum logic [2:0] {IDLE, LD_KERN, MAC, WRITE, DONE} state_e;
    state_e state, state_n;

    logic [AddrWidth-1:0]        in_base, kern_base, out_base;
    logic [NW-1:0]               n_len, nout, j, out_count;
    logic [KW-1:0]               k_len, pad, cnt;
    logic [3:0]                  stride, s_eff;
    logic [SW-1:0]               shift;
    logic                        sat, err, rd_v;
    logic [KIW-1:0]              rd_k;
    logic signed [AccWidth-1:0]  acc, shd;
    logic signed [DataWidth-1:0] kreg [MaxKernelLen];
    logic signed [DataWidth-1:0] x, res;
    logic signed [2*DataWidth-1:0] prod;
    logic [IW-1:0]               tap, idx, nout_in;
    logic                        accept, cfg_err, last_tap, in_rng, mac_rd, unused_rdata;

    assign accept   = state == IDLE && start_i && !abort_i;
    assign s_eff    = cfg_stride_i == 4'd0 ? 4'd1 : cfg_stride_i;
    assign cfg_err  = cfg_kern_len_i == '0 || IW'(cfg_kern_len_i) > IW'(MaxKernelLen) ||
                      cfg_in_len_i == '0 || (!cfg_same_i && IW'(cfg_kern_len_i) > IW'(cfg_in_len_i));
    assign nout_in  = cfg_same_i ? (IW'(cfg_in_len_i) + IW'(s_eff) - IW'(1)) / IW'(s_eff)
                                 : (IW'(cfg_in_len_i) - IW'(cfg_kern_len_i)) / IW'(s_eff) + IW'(1);
    assign last_tap = cnt == k_len;
    // tap is idx + pad, kept unsigned so negative indices show up as tap < pad
    assign tap      = IW'(j) * IW'(stride) + IW'(cnt);
    assign idx      = tap - IW'(pad);
    assign in_rng   = tap >= IW'(pad) && idx < IW'(n_len);
    assign mac_rd   = state == MAC && !last_tap && in_rng;

    assign x            = mem.rdata[DataWidth-1:0];
    assign prod         = (2*DataWidth)'(x) * (2*DataWidth)'(kreg[rd_k]);
    assign shd          = acc >>> shift;
    assign res          = DataWidth'(sat && shd > MAXV ? MAXV : sat && shd < MINV ? MINV : shd);
    assign mem.wdata    = 32'(res);
    assign unused_rdata = ^mem.rdata;
    assign err_o        = err;
    assign out_count_o  = out_count;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (cfg_err ? DONE : LD_KERN) : IDLE;
            LD_KERN: state_n = last_tap ? MAC : LD_KERN;
            MAC:     state_n = last_tap ? WRITE : MAC;
            WRITE:   state_n = j == nout - NW'(1) ? DONE : MAC;
            default: state_n = IDLE;
        endcase
        if (abort_i) state_n = IDLE;
    end

    always_comb begin
        busy_o    = state != IDLE;
        done_o    = state == DONE;
        ext_gnt_o = state == IDLE;
        mem.req   = !abort_i && ((state == LD_KERN && !last_tap) || mac_rd || state == WRITE);
        mem.we    = !abort_i && state == WRITE;
        mem.be    = mem.we ? 4'hF : 4'h0;
        mem.addr  = state == LD_KERN ? kern_base + AddrWidth'(cnt) :
                    state == MAC     ? in_base + AddrWidth'(idx) : out_base + AddrWidth'(j);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            in_base   <= '0;
            kern_base <= '0;
            out_base  <= '0;
            n_len     <= '0;
            k_len     <= '0;
            stride    <= '0;
            pad       <= '0;
            shift     <= '0;
            sat       <= 1'b0;
            nout      <= '0;
            err       <= 1'b0;
            out_count <= '0;
            j         <= '0;
            cnt       <= '0;
            acc       <= '0;
            rd_v      <= 1'b0;
            rd_k      <= '0;
            for (int i = 0; i < MaxKernelLen; i++) kreg[i] <= '0;
        end else begin
            rd_v <= mac_rd;
            rd_k <= KIW'(cnt);
            if (accept) begin
                in_base   <= cfg_in_base_i;
                kern_base <= cfg_kern_base_i;
                out_base  <= cfg_out_base_i;
                n_len     <= cfg_in_len_i;
                k_len     <= cfg_kern_len_i;
                stride    <= s_eff;
                pad       <= cfg_same_i ? (cfg_kern_len_i - KW'(1)) >> 1 : '0;
                shift     <= cfg_shift_i;
                sat       <= cfg_sat_i;
                nout      <= NW'(nout_in);
                err       <= cfg_err;
                out_count <= '0;
                j         <= '0;
                cnt       <= '0;
                acc       <= '0;
            end
            if (state == LD_KERN || state == MAC) cnt <= last_tap ? '0 : cnt + KW'(1);
            // kernel word i returns while cnt = i+1
            if (state == LD_KERN && cnt != '0) kreg[KIW'(cnt - KW'(1))] <= mem.rdata[DataWidth-1:0];
            if (rd_v) acc <= acc + AccWidth'(prod);
            if (state == WRITE && !abort_i) begin
                acc       <= '0;
                j         <= j + NW'(1);
                out_count <= out_count + NW'(1);
            end
        end
    end
endmodule

// File: tb/tb_conv1d_engine.sv
// tb_conv1d_engine: directed scoreboard bench for conv1d_engine with a behavioural SRAM
module tb_conv1d_engine;
    localparam int AW = 7;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [AW-1:0] cfg_in_base = '0, cfg_kern_base = '0, cfg_out_base = '0;
    logic [AW:0]   cfg_in_len = '0;
    logic [4:0]    cfg_kern_len = '0;
    logic [3:0]    cfg_stride = '0;
    logic          cfg_same = 1'b0, cfg_sat = 1'b0;
    logic [5:0]    cfg_shift = '0;
    logic          busy, done, err, ext_gnt;
    logic [AW:0]   out_count;
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = '0;
    logic [31:0]   sram [128];
    int            in_v [64];
    int            kn_v [16];
    logic [31:0]   ea_q [$];
    logic [31:0]   ed_q [$];
    int            checks = 0, fails = 0;

    conv1d_engine_if #(.AddrWidth(AW)) mif ();

    conv1d_engine dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .abort_i         (abort),
        .cfg_in_base_i   (cfg_in_base),
        .cfg_kern_base_i (cfg_kern_base),
        .cfg_out_base_i  (cfg_out_base),
        .cfg_in_len_i    (cfg_in_len),
        .cfg_kern_len_i  (cfg_kern_len),
        .cfg_stride_i    (cfg_stride),
        .cfg_same_i      (cfg_same),
        .cfg_shift_i     (cfg_shift),
        .cfg_sat_i       (cfg_sat),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .out_count_o     (out_count),
        .ext_gnt_o       (ext_gnt),
        .mem             (mif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we) sram[pl_addr] <= pl_data;
        if (mif.req && mif.we) sram[mif.addr] <= mif.wdata;
        if (mif.req && !mif.we) mif.rdata <= sram[mif.addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // upper half carries junk so the engine must use only the sample LSBs
    task automatic poke(input int a, input int v);
        pl_addr = AW'(a);
        pl_data = {16'hA5C3, v[15:0]};
        pl_we   = 1'b1;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    task automatic preload(input int ib, input int n, input int kb, input int k);
        for (int i = 0; i < n; i++) poke(ib + i, in_v[i]);
        for (int i = 0; i < k; i++) poke(kb + i, kn_v[i]);
    endtask

    task automatic run(input int ib, input int kb, input int ob, input int n, input int k, input int s,
                       input int same, input int sh, input int sat, input bit e_err, input int ab_c);
        int nout, nrd, s_e, p, busy_n, req_n, rd_n, done_n, exp_busy;
        longint acc, r;
        logic [15:0] t;
        bit fin;
        s_e = s == 0 ? 1 : s;
        p = same != 0 ? (k - 1) / 2 : 0;
        nout = 0;
        nrd = 0;
        if (!e_err) begin
            nout = same != 0 ? (n + s_e - 1) / s_e : (n - k) / s_e + 1;
            nrd = k;
            for (int j = 0; j < nout; j++) begin
                acc = 0;
                for (int i = 0; i < k; i++) begin
                    int idx = j * s_e + i - p;
                    if (idx >= 0 && idx < n) begin
                        acc += longint'(in_v[idx]) * longint'(kn_v[i]);
                        nrd++;
                    end
                end
                r = acc >>> sh;
                if (sat != 0) r = r > 32767 ? 32767 : r < -32768 ? -32768 : r;
                t = r[15:0];
                ea_q.push_back(32'((ob + j) % 128));
                ed_q.push_back({{16{t[15]}}, t});
            end
        end
        exp_busy = e_err ? 1 : (k + 1) + nout * (k + 2) + 1;
        cfg_in_base   = AW'(ib);
        cfg_kern_base = AW'(kb);
        cfg_out_base  = AW'(ob);
        cfg_in_len    = (AW + 1)'(n);
        cfg_kern_len  = 5'(k);
        cfg_stride    = 4'(s);
        cfg_same      = same != 0;
        cfg_shift     = 6'(sh);
        cfg_sat       = sat != 0;
        start         = 1'b1;
        busy_n = 0; req_n = 0; rd_n = 0; done_n = 0; fin = 0;
        for (int c = 1; c <= 2000 && !fin; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (mif.req) req_n++;
            if (mif.req && !mif.we) begin
                rd_n++;
                chk("rd_region", (((mif.addr - kb) & 127) < k) || (((mif.addr - ib) & 127) < n), 1);
            end
            if (mif.req && mif.we) begin
                chk("wr_pending", ea_q.size() > 0, 1);
                chk("wr_be", mif.be, 4'hF);
                if (ea_q.size() > 0) begin
                    chk("wr_addr", mif.addr, ea_q.pop_front());
                    chk("wr_data", mif.wdata, ed_q.pop_front());
                end
            end
            if (done) begin
                done_n++;
                fin = 1;
            end
            start = c == 5 && !e_err;
            if (c == 1) begin
                cfg_in_base   = AW'(ib + 3);
                cfg_kern_base = AW'(kb + 5);
                cfg_out_base  = AW'(ob + 7);
                cfg_in_len    = 3;
                cfg_kern_len  = 1;
                cfg_stride    = 2;
                cfg_same      = same == 0;
                cfg_shift     = 3;
                cfg_sat       = sat == 0;
            end
            if (ab_c >= 0) begin
                abort = c == ab_c;
                if (c == ab_c + 20) fin = 1;
            end
        end
        if (ab_c >= 0) begin
            chk("ab_done", done_n, 0);
            chk("ab_busy_cycles", busy_n, ab_c);
            chk("ab_busy", busy, 0);
            chk("ab_gnt", ext_gnt, 1);
            chk("ab_count", out_count, 2);
            chk("ab_left", ea_q.size(), nout - 2);
            ea_q.delete();
            ed_q.delete();
        end else begin
            chk("done", done_n, 1);
            chk("busy_cycles", busy_n, exp_busy);
            chk("err", err, e_err);
            chk("count", out_count, nout);
            chk("left", ea_q.size(), 0);
            if (e_err) chk("err_reqs", req_n, 0);
            else chk("reads", rd_n, nrd);
        end
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", out_count, 0);
        chk("rst_gnt", ext_gnt, 1);
        chk("rst_req", mif.req, 0);
        chk("rst_we", mif.we, 0);
        chk("rst_addr", mif.addr, 0);
        chk("rst_wdata", mif.wdata, 0);
        chk("rst_be", mif.be, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) in_v[i] = i + 1;
        kn_v[0] = 1; kn_v[1] = 2; kn_v[2] = 3;
        preload(16, 8, 0, 3);
        run(16, 0, 64, 8, 3, 1, 0, 0, 0, 0, -1);

        for (int i = 0; i < 5; i++) in_v[i] = i + 1;
        kn_v[0] = 1; kn_v[1] = 1; kn_v[2] = 1;
        preload(16, 5, 0, 3);
        run(16, 0, 64, 5, 3, 1, 1, 0, 0, 0, -1);

        run(16, 0, 64, 4, 0, 1, 0, 0, 0, 1, -1);
        run(16, 0, 64, 4, 5, 1, 0, 0, 0, 1, -1);

        for (int i = 0; i < 9; i++) in_v[i] = i;
        kn_v[0] = 1; kn_v[1] = 1;
        preload(16, 9, 0, 2);
        run(16, 0, 80, 9, 2, 3, 0, 0, 0, 0, -1);

        for (int i = 0; i < 4; i++) in_v[i] = 30000;
        kn_v[0] = 2; kn_v[1] = 2;
        preload(16, 4, 0, 2);
        run(16, 0, 64, 4, 2, 1, 0, 0, 1, 0, -1);
        run(16, 0, 64, 4, 2, 1, 0, 0, 0, 0, -1);

        in_v[0] = -5; in_v[1] = 7; in_v[2] = -3; in_v[3] = 100; in_v[4] = -200; in_v[5] = 9;
        kn_v[0] = 3; kn_v[1] = -2;
        preload(100, 6, 120, 2);
        run(100, 120, 126, 6, 2, 2, 1, 1, 1, 0, -1);

        for (int i = 0; i < 8; i++) in_v[i] = i + 1;
        kn_v[0] = 1; kn_v[1] = 2; kn_v[2] = 3;
        preload(16, 8, 0, 3);
        run(16, 0, 64, 8, 3, 1, 0, 0, 0, 0, 16);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 0);
        @(negedge clk);
        chk("sa_busy2", busy, 0);
        chk("sa_done", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
